mul8_nibble_seq: RTL and testbench

- Sequential 8x8 unsigned multiplier front-end that drives an external combinational or registered 4x4 carry-save multiplier slice through operand and product ports.
- Splits each 8-bit operand into nibbles, issues four 4x4 partial products, then shifts and accumulates the 9-bit slice results into a 16-bit product.
- Sits directly upstream of the 4x4 slice and downstream of the operand source; uses valid/ready handshakes on both sides.

---
 rtl/mul8_nibble_seq.sv | 176 +++++++++++++++++
 tb/tb_mul8_nibble_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_nibble_seq.sv
// Sequential 8x8 unsigned multiplier driving an external 4x4 slice.
// Optional multiply-accumulate (in_clr port) under MUL8_SEQ_MAC_EN.
module mul8_nibble_seq #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
`ifdef MUL8_SEQ_MAC_EN
  input  logic        in_clr,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [8:0]  mul_p
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

  localparam logic [1:0] LAT = 2'(MUL_LAT);

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  wait_q, wait_d;
  logic        load_q, load_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_p_q, out_p_d;
  logic [3:0]  mul_a_q, mul_a_d;
  logic [3:0]  mul_b_q, mul_b_d;
  logic        in_ready_q, in_ready_d;

  logic        acc_clr;
  logic [3:0]  sh;
  logic [15:0] term;
  logic [15:0] sum;
  logic [7:0]  nx;

  function automatic logic [7:0] nibs(
    input logic [1:0] s,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [3:0] na;
    logic [3:0] nb;
    na = s[0] ? a[7:4] : a[3:0];
    nb = s[1] ? b[7:4] : b[3:0];
    return {na, nb};
  endfunction

`ifdef MUL8_SEQ_MAC_EN
  assign acc_clr = in_clr;
`else
  assign acc_clr = 1'b1;
`endif

  always_comb begin
    unique case (step_q)
      2'd0:    sh = 4'd0;
      2'd3:    sh = 4'd8;
      default: sh = 4'd4;
    endcase
  end

  // slice bit 8 is kept; anything shifted past bit 15 wraps away
  assign term = {7'b0, mul_p} << sh;
  assign sum  = acc_q + term;
  assign nx   = nibs(step_q + 2'd1, a_q, b_q);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wait_d      = wait_q;
    load_d      = load_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    in_ready_d  = in_ready_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = in_a;
          b_d        = in_b;
          acc_d      = acc_clr ? 16'd0 : acc_q;
          step_d     = 2'd0;
          wait_d     = 2'd0;
          load_d     = 1'b1;
          in_ready_d = 1'b0;
          state_d    = MUL;
        end
      end
      MUL: begin
        // first MUL cycle only presents step 0 to the slice
        if (load_q) begin
          load_d           = 1'b0;
          {mul_a_d, mul_b_d} = nibs(2'd0, a_q, b_q);
        end else if (wait_q == LAT) begin
          acc_d  = sum;
          wait_d = 2'd0;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_p_d     = sum;
            mul_a_d     = 4'd0;
            mul_b_d     = 4'd0;
          end else begin
            {mul_a_d, mul_b_d} = nx;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      wait_q      <= 2'd0;
      load_q      <= 1'b0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      acc_q       <= 16'd0;
      out_valid_q <= 1'b0;
      out_p_q     <= 16'd0;
      mul_a_q     <= 4'd0;
      mul_b_q     <= 4'd0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      wait_q      <= wait_d;
      load_q      <= load_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul8_nibble_seq.sv
// Bench for mul8_nibble_seq: three lanes with MUL_LAT 0, 1 and 3,
// each with its own slice model and behavioural product model.
module tb_mul8_nibble_seq;

  localparam int ND   = 10;
  localparam int NOPS = 50;

`ifdef MUL8_SEQ_MAC_EN
  localparam bit          MAC = 1'b1;
  localparam logic [15:0] P7  = 16'h002A;
`else
  localparam bit          MAC = 1'b0;
  localparam logic [15:0] P7  = 16'h001E;
`endif

  logic clk;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  logic [7:0]  dir_a [ND] = '{8'h12, 8'hFF, 8'hA5, 8'h9C, 8'hFF,
                               8'h02, 8'h03, 8'h05, 8'h01, 8'h10};
  logic [7:0]  dir_b [ND] = '{8'h34, 8'hFF, 8'h00, 8'h3B, 8'hFF,
                               8'h03, 8'h04, 8'h06, 8'h01, 8'h10};
  logic        dir_c [ND] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] dir_p [ND] = '{16'h03A8, 16'hFE01, 16'h0000, 16'h23F4,
                               16'h0000, 16'h0006, 16'h000C, P7,
                               16'h0001, 16'h2200};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int ln,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %0h expected %0h at %0t",
               ln, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = (g == 2) ? 3 : g;

    logic        rst_n, in_valid, in_ready, out_valid, out_ready, in_clr;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_p;
    logic [3:0]  mul_a, mul_b;
    logic [8:0]  mul_p, bias;
    logic [7:0]  prod, pipe1, pipe2, pipe3, slice_out;

    assign prod = {4'b0, mul_a} * {4'b0, mul_b};
    always @(posedge clk) begin
      pipe1 <= prod;
      pipe2 <= pipe1;
      pipe3 <= pipe2;
    end
    always_comb begin
      slice_out = prod;
      case (LAT)
        0: slice_out = prod;
        1: slice_out = pipe1;
        2: slice_out = pipe2;
        default: slice_out = pipe3;
      endcase
    end
    assign mul_p = {1'b0, slice_out} + bias;

    mul8_nibble_seq #(.MUL_LAT(LAT)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
`ifdef MUL8_SEQ_MAC_EN
      .in_clr   (in_clr),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_p    (out_p),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_p    (mul_p)
    );

    initial begin : run
      int          st, c, op, pend_op, cur_op, hold, stepn, lt;
      int unsigned r;
      bit          pres, acc_nx, clr;
      logic [15:0] m_acc, m_exp, base;
      logic [7:0]  cur_a, cur_b;
      logic [3:0]  ea, eb;

      lt = 1 + 4 * (LAT + 1);
      st = 0; c = 0; op = 0; pend_op = 0; cur_op = 0; hold = 0;
      pres = 0; acc_nx = 0; m_acc = 0; m_exp = 0;
      cur_a = 0; cur_b = 0;
      rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_clr = 0;
      out_ready = 0; bias = 0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", g, in_ready, 1);
      chk("rst_out_valid", g, out_valid, 0);
      chk("rst_out_p", g, out_p, 0);
      chk("rst_mul_a", g, mul_a, 0);
      chk("rst_mul_b", g, mul_b, 0);
      rst_n = 1;

      while (op < NOPS || st != 0 || pres) begin
        @(negedge clk);
        chk("in_ready", g, in_ready, st == 0);
        chk("out_valid", g, out_valid, st == 2);
        if (st == 2) chk("out_p", g, out_p, m_exp);
        if (st != 1) begin
          chk("mul_a_idle", g, mul_a, 0);
          chk("mul_b_idle", g, mul_b, 0);
        end else if (c >= 1) begin
          stepn = (c - 1) / (LAT + 1);
          ea = stepn[0] ? cur_a[7:4] : cur_a[3:0];
          eb = stepn[1] ? cur_b[7:4] : cur_b[3:0];
          chk("mul_a_step", g, mul_a, ea);
          chk("mul_b_step", g, mul_b, eb);
        end

        // abort in the middle of step 2 of the reset test operation
        if (st == 1 && cur_op == 4 && c == 1 + 2 * (LAT + 1)) begin
          rst_n = 0;
          #1;
          chk("abort_in_ready", g, in_ready, 1);
          chk("abort_out_valid", g, out_valid, 0);
          chk("abort_out_p", g, out_p, 0);
          chk("abort_mul_a", g, mul_a, 0);
          chk("abort_mul_b", g, mul_b, 0);
          st = 0; c = 0; m_acc = 0; bias = 0;
          in_valid = 0; pres = 0; acc_nx = 0;
          @(negedge clk);
          rst_n = 1;
          continue;
        end

        if (acc_nx) begin
          in_valid = 0;
          pres = 0;
        end
        if (!pres && op < NOPS) begin
          if (op == 9 ? (st == 0) : (op < ND || $urandom_range(0, 2) == 0)) begin
            if (op < ND) begin
              in_a = dir_a[op];
              in_b = dir_b[op];
              in_clr = dir_c[op];
            end else begin
              r = $urandom_range(0, 7);
              in_a = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom_range(0, 255));
              r = $urandom_range(0, 7);
              in_b = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom_range(0, 255));
              in_clr = 1'($urandom_range(0, 1));
            end
            if (op == 9) bias = 9'h100;
            in_valid = 1;
            pres = 1;
            pend_op = op;
            op++;
          end
        end
        if (st == 2 && cur_op == 0 && hold < 7) begin
          out_ready = 0;
          hold++;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end

        acc_nx = in_valid && st == 0;
        case (st)
          0: if (acc_nx) begin
            cur_a = in_a;
            cur_b = in_b;
            cur_op = pend_op;
            clr = MAC ? in_clr : 1'b1;
            base = clr ? 16'd0 : m_acc;
            // every slice output carries the same bias, weights 1+16+16+256
            m_exp = 16'(int'(base) + int'(in_a) * int'(in_b) + int'(bias) * 289);
            m_acc = m_exp;
            if (pend_op < ND && pend_op != 4)
              chk("model_pin", g, m_exp, dir_p[pend_op]);
            st = 1;
            c = 0;
          end
          1: begin
            c++;
            if (c == lt) st = 2;
          end
          default: if (out_ready) begin
            st = 0;
            if (cur_op == 9) bias = 0;
          end
        endcase
      end
      in_valid = 0;
      done_cnt++;
    end
  end

  initial begin : main
    int t;
    t = 0;
    while (done_cnt < 3 && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < 3) begin
      checks++;
      errors++;
      $display("FAIL timeout: lanes done %0d required 3", done_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
